// File: rtl/cabac_bin_serializer_if.sv
// ----------------------------------------------------------------------------
// cabac_bin_serializer_if
// Bundles the two handshakes of the bin serializer:
//   FIFO side : data_i (76b word), data_valid_i (pop strobe), wack_o (read request)
//   Bin side  : bin_valid_o/bin_ready_i handshake with bin_mode_o, bin_val_o,
//               bin_ctx_o, bin_last_o
//   Status    : bin_cnt_o (emitted-bin counter), err_o (sticky format error)
// slave  : view of the serializer itself
// master : view of the environment (FIFO + encoder)
// ----------------------------------------------------------------------------
interface cabac_bin_serializer_if #(
    parameter int CNT_W = 16
);
    logic [75:0]      data_i;
    logic             data_valid_i;
    logic             wack_o;
    logic             bin_valid_o;
    logic             bin_ready_i;
    logic [1:0]       bin_mode_o;
    logic             bin_val_o;
    logic [8:0]       bin_ctx_o;
    logic             bin_last_o;
    logic [CNT_W-1:0] bin_cnt_o;
    logic             err_o;

    modport slave (
        input  data_i, data_valid_i, bin_ready_i,
        output wack_o, bin_valid_o, bin_mode_o, bin_val_o, bin_ctx_o,
               bin_last_o, bin_cnt_o, err_o
    );

    modport master (
        output data_i, data_valid_i, bin_ready_i,
        input  wack_o, bin_valid_o, bin_mode_o, bin_val_o, bin_ctx_o,
               bin_last_o, bin_cnt_o, err_o
    );
endinterface

// File: rtl/cabac_bin_serializer.sv
// ----------------------------------------------------------------------------
// cabac_bin_serializer
// Pops 76-bit words from the CABAC syntax-element FIFO and serializes the up to
// four packed bin slices into single bins for the binary arithmetic encoder.
// Slice k sits at data_i[75-19k -: 19] = {vld, mode[1:0], num[3:0], val[11:0]}.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (drops held word, clears counter and error)
//   bus        : cabac_bin_serializer_if.slave (FIFO pop side, bin handshake,
//                bin counter and sticky error flag)
// ----------------------------------------------------------------------------
module cabac_bin_serializer #(
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    cabac_bin_serializer_if.slave        bus
);

    localparam logic [1:0] MODE_REG = 2'd0;
    localparam logic [1:0] MODE_BYP = 2'd1;
    localparam logic [1:0] MODE_TRM = 2'd2;
    localparam logic [1:0] MODE_RSV = 2'd3;

    typedef enum logic {ST_IDLE, ST_EMIT} state_t;

    function automatic logic [18:0] slice_of(input logic [75:0] w, input logic [1:0] k);
        case (k)
            2'd0:    slice_of = w[75:57];
            2'd1:    slice_of = w[56:38];
            2'd2:    slice_of = w[37:19];
            default: slice_of = w[18:0];
        endcase
    endfunction

    // mode 3, or a bypass run longer than the 12-bit value field can supply
    function automatic logic slice_rsvd(input logic [18:0] s);
        slice_rsvd = (s[17:16] == MODE_RSV) ||
                     ((s[17:16] == MODE_BYP) && (s[15:12] > 4'd11));
    endfunction

    // Slices that produce bins; the first vld=0 slice kills all later ones.
    function automatic logic [3:0] emit_mask(input logic [75:0] w);
        logic        alive;
        logic [18:0] s;
        emit_mask = 4'b0;
        alive     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s            = slice_of(w, 2'(k));
            alive        = alive & s[18];
            emit_mask[k] = alive & ~slice_rsvd(s);
        end
    endfunction

    function automatic logic [3:0] rsvd_mask(input logic [75:0] w);
        logic        alive;
        logic [18:0] s;
        rsvd_mask = 4'b0;
        alive     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s            = slice_of(w, 2'(k));
            alive        = alive & s[18];
            rsvd_mask[k] = alive & slice_rsvd(s);
        end
    endfunction

    function automatic logic [1:0] first_idx(input logic [3:0] m);
        first_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) first_idx = 2'(k);
        end
    endfunction

    state_t           state_p1, state_nxt;
    logic [75:0]      word_p1;
    logic [1:0]       slc_p1, slc_nxt;
    logic [3:0]       bit_p1, bit_nxt;
    logic [CNT_W-1:0] cnt_p1, cnt_nxt;
    logic             err_p1, err_nxt;
    logic             load_word;

    logic             held;
    logic [18:0]      cur_s;
    logic [1:0]       cur_mode;
    logic [3:0]       cur_num;
    logic [15:0]      cur_val16;
    logic [3:0]       bit_idx;
    logic [3:0]       held_mask;
    logic [3:0]       hi_mask;
    logic [1:0]       next_slc;
    logic             last_in_slice;
    logic             last_slice;
    logic             bin_last;
    logic             hs;
    logic             wack;
    logic             cap;
    logic [3:0]       in_mask;
    logic             in_rsvd;

    // ---- held word decode (current slice / bin) ----
    assign held          = (state_p1 == ST_EMIT);
    assign cur_s         = slice_of(word_p1, slc_p1);
    assign cur_mode      = cur_s[17:16];
    assign cur_num       = cur_s[15:12];
    assign cur_val16     = {4'b0, cur_s[11:0]};
    assign bit_idx       = cur_num - bit_p1;
    assign held_mask     = emit_mask(word_p1);
    // emitting slices strictly after the current one
    assign hi_mask       = held_mask & (4'b1110 << slc_p1);
    assign next_slc      = first_idx(hi_mask);
    assign last_in_slice = (cur_mode != MODE_BYP) || (bit_p1 == cur_num);
    assign last_slice    = (hi_mask == 4'b0);
    assign bin_last      = held && last_in_slice && last_slice;
    assign hs            = held && bus.bin_ready_i;

    // ---- FIFO side: request a new word when idle or finishing the last bin ----
    assign wack    = !clr_i && (!held || (hs && bin_last));
    assign cap     = bus.data_valid_i && wack;
    assign in_mask = emit_mask(bus.data_i);
    assign in_rsvd = |rsvd_mask(bus.data_i);

    // Outputs are forced to zero while idle so the undriven word register
    // never leaks onto the bin bus.
    always_comb begin
        bus.bin_valid_o = held;
        bus.bin_mode_o  = 2'd0;
        bus.bin_val_o   = 1'b0;
        bus.bin_ctx_o   = 9'd0;
        if (held) begin
            bus.bin_mode_o = cur_mode;
            if (cur_mode == MODE_BYP) begin
                bus.bin_val_o = cur_val16[bit_idx];
            end else begin
                bus.bin_val_o = cur_val16[0];
            end
            if (cur_mode == MODE_REG) begin
                bus.bin_ctx_o = cur_val16[9:1];
            end
        end
    end

    assign bus.bin_last_o = bin_last;
    assign bus.wack_o     = wack;
    assign bus.bin_cnt_o  = cnt_p1;
    assign bus.err_o      = err_p1;

    // ---- next-state: advance on handshake, reload on capture, clear wins ----
    always_comb begin
        state_nxt = state_p1;
        slc_nxt   = slc_p1;
        bit_nxt   = bit_p1;
        cnt_nxt   = cnt_p1;
        err_nxt   = err_p1;
        load_word = 1'b0;
        if (clr_i) begin
            state_nxt = ST_IDLE;
            slc_nxt   = 2'd0;
            bit_nxt   = 4'd0;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
        end else begin
            if (hs) begin
                cnt_nxt = cnt_p1 + CNT_W'(1);
                if (!last_in_slice) begin
                    bit_nxt = bit_p1 + 4'd1;
                end else if (!last_slice) begin
                    slc_nxt = next_slc;
                    bit_nxt = 4'd0;
                end else begin
                    state_nxt = ST_IDLE;
                    slc_nxt   = 2'd0;
                    bit_nxt   = 4'd0;
                end
            end
            // capture only happens when idle or at end of word, so it may
            // safely override the advance above
            if (cap) begin
                load_word = 1'b1;
                err_nxt   = err_p1 | in_rsvd;
                if (|in_mask) begin
                    state_nxt = ST_EMIT;
                    slc_nxt   = first_idx(in_mask);
                    bit_nxt   = 4'd0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        end
    end

    // ---- control registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= ST_IDLE;
            slc_p1   <= 2'd0;
            bit_p1   <= 4'd0;
            cnt_p1   <= '0;
            err_p1   <= 1'b0;
        end else begin
            state_p1 <= state_nxt;
            slc_p1   <= slc_nxt;
            bit_p1   <= bit_nxt;
            cnt_p1   <= cnt_nxt;
            err_p1   <= err_nxt;
        end
    end

    // ---- data register ----
    always_ff @(posedge clk) begin
        if (load_word) begin
            word_p1 <= bus.data_i;
        end
    end

endmodule

// File: doc/cabac_bin_serializer.md
Name: cabac_bin_serializer

Overview:
- Consumer stage directly downstream of the CABAC syntax-element FIFO; front end of binarization.
- Pops one 76-bit word at a time using the FIFO's read-acknowledge handshake. Each word holds up to 4 packed bin slices.
- Emits one bin per handshake to the binary arithmetic encoder, with mode (regular/bypass/terminate), context index and bin value.
- Keeps a running bin counter and a sticky format-error flag.

Parameters:
- CNT_W, 16, width of emitted-bin counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous clear: drop held word, clear counter and error
- data_i  in  76  FIFO word; valid only when data_valid_i=1
- data_valid_i  in  1  FIFO pop strobe; same-cycle response to wack_o
- wack_o  out  1  read request to FIFO
- bin_valid_o  out  1  bin available
- bin_ready_i  in  1  encoder accepts bin
- bin_mode_o  out  2  0 regular, 1 bypass, 2 terminate
- bin_val_o  out  1  bin value
- bin_ctx_o  out  9  context index (regular only, else 0)
- bin_last_o  out  1  last bin of current word
- bin_cnt_o  out  CNT_W  bins handshaken since reset/clear; wraps
- err_o  out  1  sticky reserved-encoding flag

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk.
- Reset values: held=0, slice/bin pointers=0, bin_valid_o=0, bin_mode_o=0, bin_val_o=0, bin_ctx_o=0, bin_last_o=0, bin_cnt_o=0, err_o=0, wack_o=1 once rst_n deasserts.
- Word format: slice k occupies data_i[75-19k -: 19], k=0..3, processed in order 0 to 3.
- Slice fields, MSB first: vld(1), mode(2), num(4), val(12).
- Slice termination: a slice with vld=0 ends the word; later slices are ignored.
- Regular slice: ctx=val[9:1], bin=val[0]; emits 1 bin.
- Terminate slice: bin=val[0], ctx=0; emits 1 bin.
- Bypass slice: emits num+1 bins, MSB first (val[num] down to val[0]).
- Reserved encodings: mode=3, or bypass with num>11. The slice is skipped (no bins) and err_o is set.
- wack_o = !clr_i && (!held || (bin_valid_o && bin_ready_i && bin_last_o)). This gives back-to-back words with no bubble.
- Word capture: the word is latched at the edge where data_valid_i=1. data_valid_i is never refused.
  - If the word contains at least one emitting slice, held=1 and pointers are set to the first emitting slice, bin 0.
  - Otherwise the word is dropped, held stays 0, and err_o is updated if a reserved slice was present.
- Latency: word latched at edge N; its first bin is on the outputs in cycle N+1. bin_* outputs are combinational from the held word and pointers.
- bin_valid_o = held.
- Advance occurs only on bin_valid_o && bin_ready_i:
  - Next bypass bit within the slice; else
  - Next emitting slice (skipping reserved ones); else end of word.
  - At end of word, held takes the value determined by a simultaneous capture, if any.
- bin_last_o=1 when the current bin is the last bin of the last emitting slice.
- Stall: while bin_ready_i=0, all bin_* outputs hold stable.
- bin_cnt_o increments by 1 per handshake and wraps from 2^CNT_W-1 to 0.
- clr_i takes priority over everything:
  - Next edge: held=0, counter=0, err_o=0.
  - wack_o=0 in the clr_i cycle, so no pop is lost.
  - A handshake in the same cycle is not counted.
- rst_n mid-word: the held word is lost; the FIFO is reset in the same domain.

Test Plan:
- Single word; slice0 regular ctx=5 bin=1; slice1 vld=0.
  -> Cycle after pop: bin_valid_o=1, mode=0, ctx=5, val=1, last=1.
  -> With bin_ready_i=1: bin_cnt_o=1, wack_o=1.
- Bypass slice num=3, val[3:0]=1010, followed by terminate val=1, ready held high.
  -> Bins 1,0,1,0 (mode 1), then 1 (mode 2, last=1) on 5 consecutive cycles. bin_cnt_o=5.
- Two words, FIFO non-empty, ready=1.
  -> wack_o high on the last-bin cycle; second word's first bin appears the very next cycle (no bubble).
- Slice0 mode=3, slice1 regular ctx=300 bin=0.
  -> Only one bin emitted (ctx=300, val=0); err_o=1 and stays 1.
- Word with slice0 vld=0.
  -> No bins, held=0, wack_o stays 1. Next word is accepted the following cycle.
- Stall: ready=0 for 4 cycles mid-bypass, then clr_i pulse.
  -> Outputs are stable during the stall. After clr_i: bin_valid_o=0, bin_cnt_o=0, err_o=0, and wack_o=0 during the clr_i cycle.
